tweet_ram_sched: RTL and testbench
==================================

# tweet_ram_sched

Arbiter and sequencer for the tweetboard's single-port 256×16 message RAM. It shares the RAM between three requesters: the power-on/user clear sweep, the serial-receive character writer, and the playback reader feeding the serial transmitter. It owns the write pointer, the read pointer and all RAM control signals. It sits between the receiver/transmitter control logic and the `ram` instance.

## Interface
- `MAX_LEN`, 160: maximum stored characters; valid write addresses are 0..MAX_LEN-1.
- `CLR_DEPTH`, 256: number of RAM words cleared by a sweep.

Ports:
- `sysclk` in 1: system clock; everything is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `clear_req` in 1: single-cycle pulse requesting a full RAM clear.
- `wr_req` in 1: level; held until `wr_ack` or `wr_drop`.
- `wr_data` in 8: received character; stable while `wr_req` is high.
- `rd_start` in 1: single-cycle pulse; rewinds the read pointer to 0.
- `rd_req` in 1: level; held until `rd_ack`.
- `ram_data_out` in 16: RAM registered read data, valid one cycle after the address.
- `ram_write` out 1: RAM write strobe.
- `ram_addr` out 8: RAM address.
- `ram_data_in` out 16: RAM write data.
- `wr_ack` out 1: one-cycle pulse; the character was stored or the backspace was applied.
- `wr_drop` out 1: one-cycle pulse; write rejected because the buffer is full.
- `rd_ack` out 1: one-cycle pulse completing a read.
- `rd_valid` out 1: qualifies `rd_data`; meaningful only with `rd_ack`.
- `rd_end` out 1: high with `rd_ack` when no more characters remain.
- `rd_data` out 8: character read.
- `busy` out 1: high while a clear sweep is pending or running.
- `count` out 8: current write pointer, equal to the number of stored characters.

## Operation
- Stored word format: {1'b1, 7'b0, char}. Bit 15 is the valid flag; a word of all zeros is empty.
- States: `IDLE`, `CLR`, `WR`, `RD`, `RDW`.
- Arbitration in `IDLE`, fixed priority: pending clear, then `wr_req`, then `rd_req`. Exactly one request is granted per pass through `IDLE`.
- `clear_req` sets a pending flag in any state. The flag is taken at the next `IDLE`; an in-flight operation finishes first.
- `CLR`: sweep address 0..CLR_DEPTH-1 with `ram_write`=1 and data 0, one word per cycle. After the sweep: write pointer `wp`=0, read pointer `rp`=0, pending flag cleared, return to `IDLE`.
- `WR` (normal character): if `wp`<MAX_LEN, write {1,7'b0,`wr_data`} at `wp`, pulse `wr_ack`, then `wp`+1. Otherwise no RAM write and `wr_drop` pulses.
- `RD`: if `rp`==MAX_LEN, skip the RAM access and complete at once with `rd_end`=1 and `rd_valid`=0. Otherwise drive `ram_addr`=`rp` with `ram_write`=0, then go to `RDW`.
- `RDW`: if `ram_data_out[15]`=1, then `rd_valid`=1, `rd_data`=`ram_data_out[7:0]`, and `rp`+1. If it is 0, then `rd_end`=1 and `rp` is unchanged. `rd_ack` pulses in both cases; return to `IDLE`.
- `rd_start` sets `rp`=0 in any state except `CLR`, where it is ignored. If it coincides with the `RDW` increment, `rd_start` wins.
- `ram_addr`, `ram_data_in` and `ram_write` are registered outputs. `ram_write` is 0 whenever the block is not in `CLR` or `WR`.

## Timing
- Reset values: all outputs 0, `wp`=`rp`=0, state `IDLE`, clear pending=1. As a result, `busy`=1 from the first cycle after reset and a full sweep runs automatically.
- Clear sweep: `busy`=1 from the cycle after `clear_req` until the cycle after address CLR_DEPTH-1 is written. The sweep is CLR_DEPTH write cycles plus 1 grant cycle.
- Write: `wr_req` seen in `IDLE` at cycle N. The RAM write and `wr_ack` (or `wr_drop`) occur at cycle N+1, and `count` updates at N+2. The requester drops `wr_req` on seeing the ack; a new request is accepted at N+2 at the earliest.
- Read: `rd_req` seen at cycle N. The address is driven at N+1 and `rd_ack` occurs at N+2. The full-pointer case (`rp`==MAX_LEN) acks at N+1.
- `reset` mid-operation aborts immediately; the in-progress write or read is lost and a new sweep follows.
- A `clear_req` arriving during `CLR` is absorbed; no second sweep runs.

## Configuration
- `TWEET_BACKSPACE_EN` defined: `wr_data`==8'h08 is a backspace.
  - If `wp`>0: write 0 at `wp`-1, set `wp`-1, pulse `wr_ack`.
  - If `wp`==0: no RAM write, but `wr_ack` still pulses.
  - A backspace is never dropped for a full buffer.
- `TWEET_BACKSPACE_EN` not defined: 8'h08 is stored like any other character.

## Structure
- Package `tweet_pkg` holds:
  - the state enum;
  - `VALID_BIT`=15;
  - `BS_CHAR`=8'h08;
  - `WORD_W`=16;
  - the empty-word constant.
- Sub-module `ram_sweep` contains the clear address counter, with a start input and done/addr outputs. All other logic stays in the top module.

## Test plan
- Reset → `busy`=1 for 257 cycles, RAM addresses 0..255 written with 0; afterwards `count`=0 and `busy`=0.
- Write 'H' (8'h48) then 'i' (8'h69) → RAM[0]=16'h8048, RAM[1]=16'h8069, `count`=2, each `wr_ack` one cycle after grant. Then `rd_start` followed by three reads → 'H' and 'i' with `rd_valid`, then `rd_end`.
- 161 writes → the first 160 are acked and the 161st gives `wr_drop`; `count` stays 160 and RAM[160] remains 0.
- `TWEET_BACKSPACE_EN`: write 'a', 'b', then 8'h08 → RAM[1]=0, `count`=1; a backspace at `count`=0 → `wr_ack` with no write.
- `wr_req`, `rd_req` and `clear_req` asserted in the same cycle → sweep runs first, then the write is acked, then `rd_ack` returns the newly written character at address 0.
- `reset` asserted in the cycle after a write grant → no `wr_ack`, a new sweep starts, and `count`=0.

Source files
------------

// File: rtl/tweet_pkg.sv
// Shared types and constants for the tweetboard message-RAM scheduler.
package tweet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        WR,
        RD,
        RDW
    } state_t;

    localparam int               VALID_BIT  = 15;
    localparam logic [7:0]       BS_CHAR    = 8'h08;
    localparam int               WORD_W     = 16;
    localparam logic [WORD_W-1:0] EMPTY_WORD = '0;

    function automatic logic [WORD_W-1:0] char_word(input logic [7:0] c);
        return {1'b1, 7'b0, c};
    endfunction

    function automatic logic is_bs_char(input logic [7:0] c);
        return c == BS_CHAR;
    endfunction

endpackage

// File: rtl/ram_sweep.sv
// Address counter for the RAM clear sweep; o_next_addr is the word written after the current one.
module ram_sweep #(
    parameter int DEPTH = 256
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_step,
    output logic [7:0] o_next_addr,
    output logic       o_done
);

    logic [7:0] r_cnt;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_cnt <= 8'd0;
        end else if (i_start) begin
            r_cnt <= 8'd0;
        end else if (i_step) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_next_addr = r_cnt + 8'd1;
    assign o_done      = (r_cnt == 8'(DEPTH - 1));

endmodule

// File: rtl/tweet_ram_sched.sv
// Arbiter/sequencer sharing the single-port message RAM between clear, write and playback.
// Optional feature: define TWEET_BACKSPACE_EN to treat 8'h08 as a backspace.
module tweet_ram_sched
    import tweet_pkg::*;
#(
    parameter int MAX_LEN   = 160,
    parameter int CLR_DEPTH = 256
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              wr_req,
    input  logic [7:0]        wr_data,
    input  logic              rd_start,
    input  logic              rd_req,
    input  logic [WORD_W-1:0] ram_data_out,
    output logic              ram_write,
    output logic [7:0]        ram_addr,
    output logic [WORD_W-1:0] ram_data_in,
    output logic              wr_ack,
    output logic              wr_drop,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic              rd_end,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic [7:0]        count
);

    localparam logic [7:0] MAX_W = 8'(MAX_LEN);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_wp, r_rp;
    logic              r_clr_pend;
    logic              r_ram_write, w_ram_write_nxt;
    logic [7:0]        r_ram_addr, w_ram_addr_nxt;
    logic [WORD_W-1:0] r_ram_data_in, w_ram_data_nxt;
    logic              w_clr_any, w_is_bs, w_has_room, w_rd_hit;
    logic              w_sweep_start, w_sweep_step, w_sweep_done;
    logic [7:0]        w_sweep_next;
    logic              w_unused_data;

`ifdef TWEET_BACKSPACE_EN
    assign w_is_bs = is_bs_char(wr_data);
`else
    assign w_is_bs = 1'b0;
`endif

    assign w_clr_any     = r_clr_pend | clear_req;
    assign w_has_room    = (r_wp < MAX_W);
    assign w_rd_hit      = ram_data_out[VALID_BIT];
    assign w_unused_data = ^ram_data_out[14:8];

    ram_sweep #(.DEPTH(CLR_DEPTH)) u_sweep (
        .sysclk      (sysclk),
        .reset       (reset),
        .i_start     (w_sweep_start),
        .i_step      (w_sweep_step),
        .o_next_addr (w_sweep_next),
        .o_done      (w_sweep_done)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_ram_write_nxt = 1'b0;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_data_nxt  = r_ram_data_in;
        w_sweep_start   = 1'b0;
        w_sweep_step    = 1'b0;
        wr_ack          = 1'b0;
        wr_drop         = 1'b0;
        rd_ack          = 1'b0;
        rd_valid        = 1'b0;
        rd_end          = 1'b0;
        rd_data         = 8'd0;
        case (r_state)
            IDLE: begin
                if (w_clr_any) begin
                    w_state_nxt     = CLR;
                    w_sweep_start   = 1'b1;
                    w_ram_write_nxt = 1'b1;
                    w_ram_addr_nxt  = 8'd0;
                    w_ram_data_nxt  = EMPTY_WORD;
                end else if (wr_req) begin
                    w_state_nxt = WR;
                    if (w_is_bs) begin
                        if (r_wp != 8'd0) begin
                            w_ram_write_nxt = 1'b1;
                            w_ram_addr_nxt  = r_wp - 8'd1;
                            w_ram_data_nxt  = EMPTY_WORD;
                        end
                    end else if (w_has_room) begin
                        w_ram_write_nxt = 1'b1;
                        w_ram_addr_nxt  = r_wp;
                        w_ram_data_nxt  = char_word(wr_data);
                    end
                end else if (rd_req) begin
                    w_state_nxt    = RD;
                    w_ram_addr_nxt = r_rp;
                end
            end
            CLR: begin
                w_sweep_step = 1'b1;
                if (w_sweep_done) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_ram_write_nxt = 1'b1;
                    w_ram_addr_nxt  = w_sweep_next;
                    w_ram_data_nxt  = EMPTY_WORD;
                end
            end
            WR: begin
                w_state_nxt = IDLE;
                wr_ack      = w_is_bs | w_has_room;
                wr_drop     = ~(w_is_bs | w_has_room);
            end
            RD: begin
                if (r_rp == MAX_W) begin
                    w_state_nxt = IDLE;
                    rd_ack      = 1'b1;
                    rd_end      = 1'b1;
                end else begin
                    w_state_nxt = RDW;
                end
            end
            RDW: begin
                w_state_nxt = IDLE;
                rd_ack      = 1'b1;
                if (w_rd_hit) begin
                    rd_valid = 1'b1;
                    rd_data  = ram_data_out[7:0];
                end else begin
                    rd_end = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A reset cycle aborts the operation in flight, so no handshake may escape it.
        if (reset) begin
            wr_ack   = 1'b0;
            wr_drop  = 1'b0;
            rd_ack   = 1'b0;
            rd_valid = 1'b0;
            rd_end   = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wp          <= 8'd0;
            r_rp          <= 8'd0;
            r_clr_pend    <= 1'b1;
            r_ram_write   <= 1'b0;
            r_ram_addr    <= 8'd0;
            r_ram_data_in <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ram_write   <= w_ram_write_nxt;
            r_ram_addr    <= w_ram_addr_nxt;
            r_ram_data_in <= w_ram_data_nxt;

            // Pending stays set through the sweep so requests arriving mid-sweep are absorbed.
            if (r_state == CLR) begin
                if (w_sweep_done) begin
                    r_clr_pend <= 1'b0;
                end
            end else if (clear_req) begin
                r_clr_pend <= 1'b1;
            end

            if (r_state == CLR) begin
                if (w_sweep_done) begin
                    r_wp <= 8'd0;
                end
            end else if (r_state == WR) begin
                if (w_is_bs) begin
                    if (r_wp != 8'd0) begin
                        r_wp <= r_wp - 8'd1;
                    end
                end else if (w_has_room) begin
                    r_wp <= r_wp + 8'd1;
                end
            end

            if (r_state == CLR) begin
                if (w_sweep_done) begin
                    r_rp <= 8'd0;
                end
            end else if (rd_start) begin
                r_rp <= 8'd0;
            end else if (r_state == RDW && w_rd_hit) begin
                r_rp <= r_rp + 8'd1;
            end
        end
    end

    assign ram_write   = r_ram_write;
    assign ram_addr    = r_ram_addr;
    assign ram_data_in = r_ram_data_in;
    assign busy        = r_clr_pend;
    assign count       = r_wp;

endmodule

// File: tb/tb_tweet_ram_sched.sv
// Directed testbench for tweet_ram_sched with a behavioural 256x16 registered-read RAM.
module tb_tweet_ram_sched;

    logic        sysclk = 1'b0;
    logic        reset, clear_req, wr_req, rd_start, rd_req;
    logic [7:0]  wr_data;
    logic [15:0] ram_data_out;
    logic        ram_write;
    logic [7:0]  ram_addr;
    logic [15:0] ram_data_in;
    logic        wr_ack, wr_drop, rd_ack, rd_valid, rd_end, busy;
    logic [7:0]  rd_data, count;

    logic [15:0] mem [256];
    int          ramWrites = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 sysclk = ~sysclk;

    tweet_ram_sched dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .clear_req    (clear_req),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rd_start     (rd_start),
        .rd_req       (rd_req),
        .ram_data_out (ram_data_out),
        .ram_write    (ram_write),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .wr_ack       (wr_ack),
        .wr_drop      (wr_drop),
        .rd_ack       (rd_ack),
        .rd_valid     (rd_valid),
        .rd_end       (rd_end),
        .rd_data      (rd_data),
        .busy         (busy),
        .count        (count)
    );

    // Registered-read RAM: read data reflects the word before any same-cycle write.
    always @(posedge sysclk) begin
        ram_data_out <= mem[ram_addr];
        if (ram_write) begin
            mem[ram_addr] <= ram_data_in;
            ramWrites = ramWrites + 1;
        end
    end

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic doWrite(input logic [7:0] ch, output logic ack, output logic drop, output int lat);
        ack = 1'b0; drop = 1'b0; lat = 0;
        wr_data = ch;
        wr_req  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (wr_ack || wr_drop) begin
                ack = wr_ack; drop = wr_drop; lat = i;
                break;
            end
        end
        wr_req = 1'b0;
        step();
    endtask

    task automatic doRead(output logic ack, output logic valid, output logic endf,
                          output logic [7:0] data, output int lat);
        ack = 1'b0; valid = 1'b0; endf = 1'b0; data = 8'd0; lat = 0;
        rd_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (rd_ack) begin
                ack = 1'b1; valid = rd_valid; endf = rd_end; data = rd_data; lat = i;
                break;
            end
        end
        rd_req = 1'b0;
        step();
    endtask

    task automatic doClear(output int busyCycles);
        busyCycles = 0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            busyCycles++;
            step();
        end
    endtask

    task automatic pulseRdStart();
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
    endtask

    task automatic test_reset();
        int busyCycles, expAddr, sweepBad, zeroBad;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got %b want 1", busy); end
        checks++; if ({wr_ack, wr_drop, rd_ack, rd_valid, rd_end, ram_write} !== 6'b0 || count !== 8'd0)
            begin errors++; $display("[TB] FAIL reset_outputs: got %b/%0d want 0/0", {wr_ack, wr_drop, rd_ack, rd_valid, rd_end, ram_write}, count); end
        busyCycles = 1; expAddr = 0; sweepBad = 0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (ram_write) begin
                if (ram_addr !== 8'(expAddr) || ram_data_in !== 16'h0) sweepBad++;
                expAddr++;
            end
            if (busy) busyCycles++;
            else break;
        end
        checks++; if (busyCycles != 257) begin errors++; $display("[TB] FAIL reset_busy_len: got %0d want 257", busyCycles); end
        checks++; if (expAddr != 256 || sweepBad != 0) begin errors++; $display("[TB] FAIL reset_sweep: got %0d writes %0d bad want 256 writes 0 bad", expAddr, sweepBad); end
        zeroBad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== 16'h0) zeroBad++;
        checks++; if (zeroBad != 0) begin errors++; $display("[TB] FAIL reset_ram_zero: got %0d nonzero want 0", zeroBad); end
        checks++; if (count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", count); end
    endtask

    task automatic test_write_read();
        logic ack, drop, valid, endf;
        logic [7:0] data;
        int lat;
        doWrite(8'h48, ack, drop, lat);
        checks++; if ({ack, drop} !== 2'b10 || lat != 1) begin errors++; $display("[TB] FAIL write_H_ack: got ack %b drop %b lat %0d want 1 0 1", ack, drop, lat); end
        checks++; if (mem[0] !== 16'h8048) begin errors++; $display("[TB] FAIL write_H_ram: got %h want 8048", mem[0]); end
        doWrite(8'h69, ack, drop, lat);
        checks++; if ({ack, drop} !== 2'b10 || lat != 1) begin errors++; $display("[TB] FAIL write_i_ack: got ack %b drop %b lat %0d want 1 0 1", ack, drop, lat); end
        checks++; if (mem[1] !== 16'h8069 || count !== 8'd2) begin errors++; $display("[TB] FAIL write_i_ram: got %h count %0d want 8069 count 2", mem[1], count); end
        doRead(ack, valid, endf, data, lat);
        checks++; if ({ack, valid, endf} !== 3'b110 || data !== 8'h48 || lat != 2) begin errors++; $display("[TB] FAIL read_pre: got %b %h lat %0d want 110 48 2", {ack, valid, endf}, data, lat); end
        pulseRdStart();
        doRead(ack, valid, endf, data, lat);
        checks++; if ({ack, valid, endf} !== 3'b110 || data !== 8'h48 || lat != 2) begin errors++; $display("[TB] FAIL read_H: got %b %h lat %0d want 110 48 2", {ack, valid, endf}, data, lat); end
        doRead(ack, valid, endf, data, lat);
        checks++; if ({ack, valid, endf} !== 3'b110 || data !== 8'h69 || lat != 2) begin errors++; $display("[TB] FAIL read_i: got %b %h lat %0d want 110 69 2", {ack, valid, endf}, data, lat); end
        doRead(ack, valid, endf, data, lat);
        checks++; if ({ack, valid, endf} !== 3'b101 || lat != 2) begin errors++; $display("[TB] FAIL read_end: got %b lat %0d want 101 2", {ack, valid, endf}, lat); end
    endtask

    task automatic test_clear();
        int busyCycles, busyAgain;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            busyCycles++;
            if (i == 100) clear_req = 1'b1;
            step();
            clear_req = 1'b0;
        end
        checks++; if (busyCycles != 256) begin errors++; $display("[TB] FAIL clear_busy_len: got %0d want 256", busyCycles); end
        busyAgain = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) busyAgain++;
            step();
        end
        checks++; if (busyAgain != 0) begin errors++; $display("[TB] FAIL clear_absorb: got %0d busy cycles want 0", busyAgain); end
        checks++; if (count !== 8'd0 || mem[0] !== 16'h0 || mem[1] !== 16'h0) begin errors++; $display("[TB] FAIL clear_state: got count %0d ram %h %h want 0 0000 0000", count, mem[0], mem[1]); end
    endtask

    task automatic test_full();
        logic ack, drop, valid, endf;
        logic [7:0] data, ch;
        int lat, w0, ackBad, readBad;
        w0 = ramWrites; ackBad = 0;
        for (int i = 0; i < 160; i++) begin
            ch = 8'h20 + 8'(i % 90);
            doWrite(ch, ack, drop, lat);
            if ({ack, drop} !== 2'b10 || lat != 1) ackBad++;
        end
        checks++; if (ackBad != 0) begin errors++; $display("[TB] FAIL full_acks: got %0d bad acks want 0", ackBad); end
        doWrite(8'h7A, ack, drop, lat);
        checks++; if ({ack, drop} !== 2'b01 || lat != 1) begin errors++; $display("[TB] FAIL full_drop: got ack %b drop %b lat %0d want 0 1 1", ack, drop, lat); end
        checks++; if (count !== 8'd160 || ramWrites - w0 != 160) begin errors++; $display("[TB] FAIL full_count: got count %0d writes %0d want 160 160", count, ramWrites - w0); end
        checks++; if (mem[159] !== 16'h8065 || mem[160] !== 16'h0) begin errors++; $display("[TB] FAIL full_ram: got %h %h want 8065 0000", mem[159], mem[160]); end
        pulseRdStart();
        readBad = 0;
        for (int i = 0; i < 160; i++) begin
            doRead(ack, valid, endf, data, lat);
            if ({ack, valid, endf} !== 3'b110 || data !== 8'h20 + 8'(i % 90) || lat != 2) readBad++;
        end
        checks++; if (readBad != 0) begin errors++; $display("[TB] FAIL full_readback: got %0d bad reads want 0", readBad); end
        doRead(ack, valid, endf, data, lat);
        checks++; if ({ack, valid, endf} !== 3'b101 || lat != 1) begin errors++; $display("[TB] FAIL full_rp_end: got %b lat %0d want 101 1", {ack, valid, endf}, lat); end
    endtask

    task automatic test_backspace();
        logic ack, drop;
        int lat, cyc, w0;
        doClear(cyc);
        checks++; if (cyc != 256 || count !== 8'd0) begin errors++; $display("[TB] FAIL bs_clear: got %0d cycles count %0d want 256 0", cyc, count); end
`ifdef TWEET_BACKSPACE_EN
        doWrite(8'h61, ack, drop, lat);
        doWrite(8'h62, ack, drop, lat);
        doWrite(8'h08, ack, drop, lat);
        checks++; if ({ack, drop} !== 2'b10 || mem[1] !== 16'h0 || mem[0] !== 16'h8061 || count !== 8'd1)
            begin errors++; $display("[TB] FAIL bs_erase: got ack %b drop %b ram %h %h count %0d want 1 0 8061 0000 1", ack, drop, mem[0], mem[1], count); end
        doWrite(8'h08, ack, drop, lat);
        checks++; if (mem[0] !== 16'h0 || count !== 8'd0) begin errors++; $display("[TB] FAIL bs_erase0: got %h count %0d want 0000 0", mem[0], count); end
        w0 = ramWrites;
        doWrite(8'h08, ack, drop, lat);
        checks++; if ({ack, drop} !== 2'b10 || ramWrites != w0 || count !== 8'd0)
            begin errors++; $display("[TB] FAIL bs_empty: got ack %b drop %b writes %0d count %0d want 1 0 0 0", ack, drop, ramWrites - w0, count); end
`else
        w0 = ramWrites;
        doWrite(8'h08, ack, drop, lat);
        checks++; if ({ack, drop} !== 2'b10 || mem[0] !== 16'h8008 || count !== 8'd1 || ramWrites - w0 != 1)
            begin errors++; $display("[TB] FAIL bs_as_char: got ack %b ram %h count %0d want 1 8008 1", ack, mem[0], count); end
`endif
    endtask

    task automatic test_back_to_back();
        int wrLat, rdLat;
        logic early, valid;
        logic [7:0] data;
        wr_data = 8'h51; wr_req = 1'b1; rd_req = 1'b1; clear_req = 1'b1;
        early = 1'b0; wrLat = 0; rdLat = 0; valid = 1'b0; data = 8'd0;
        for (int i = 1; i <= 400; i++) begin
            step();
            clear_req = 1'b0;
            if (rd_ack) early = 1'b1;
            if (wr_ack) begin wrLat = i; break; end
        end
        wr_req = 1'b0;
        for (int j = 1; j <= 20; j++) begin
            step();
            if (rd_ack) begin rdLat = j; valid = rd_valid; data = rd_data; break; end
        end
        rd_req = 1'b0;
        step();
        checks++; if (wrLat != 258 || early !== 1'b0) begin errors++; $display("[TB] FAIL b2b_wr_after_clear: got lat %0d early rd %b want 258 0", wrLat, early); end
        checks++; if (rdLat != 3 || valid !== 1'b1 || data !== 8'h51) begin errors++; $display("[TB] FAIL b2b_rd: got lat %0d valid %b data %h want 3 1 51", rdLat, valid, data); end
        checks++; if (mem[0] !== 16'h8051 || count !== 8'd1) begin errors++; $display("[TB] FAIL b2b_state: got %h count %0d want 8051 1", mem[0], count); end
    endtask

    task automatic test_reset_abort();
        int cyc;
        wr_data = 8'h5A; wr_req = 1'b1;
        step();
        reset = 1'b1;
        #1;
        checks++; if (wr_ack !== 1'b0 || wr_drop !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_ack: got ack %b drop %b want 0 0", wr_ack, wr_drop); end
        step();
        reset = 1'b0; wr_req = 1'b0;
        checks++; if (busy !== 1'b1 || count !== 8'd0) begin errors++; $display("[TB] FAIL abort_restart: got busy %b count %0d want 1 0", busy, count); end
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            cyc++;
            step();
        end
        checks++; if (cyc != 257 || count !== 8'd0 || mem[0] !== 16'h0 || mem[1] !== 16'h0)
            begin errors++; $display("[TB] FAIL abort_sweep: got %0d cycles count %0d ram %h %h want 257 0 0000 0000", cyc, count, mem[0], mem[1]); end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'hFFFF;
        reset = 1'b1; clear_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0; rd_start = 1'b0; wr_data = 8'd0;
        test_reset();
        test_write_read();
        test_clear();
        test_full();
        test_backspace();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
